fetch_prefetch_queue: RTL and testbench

Parametrised fetch stage for the pipelined core, replacing the single-cycle fetch path. It adds an instruction prefetch queue of configurable depth and a request/grant/response handshake to an instruction memory with variable latency. It also adds redirect handling that flushes queued and in-flight instructions. It sits between the instruction memory and the Fetch/Decode pipeline register, and its redirect inputs come from Execute (branch) and Writeback (PC write).

---
 rtl/fetch_prefetch_queue.sv | 162 ++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with a prefetch queue and a single-outstanding request/grant/response
// port to instruction memory; branch/PC-write redirects flush queued and in-flight work.
module fetch_prefetch_queue #(
    parameter int unsigned     BITS     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [BITS-1:0] RESET_PC = '0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       BranchE,
    input  logic [BITS-1:0]            ALUSResultE,
    input  logic                       PCSrcW,
    input  logic [BITS-1:0]            ResultW,
    input  logic                       StallF,
    output logic                       IMemReq,
    output logic [BITS-1:0]            IMemAddr,
    input  logic                       IMemGnt,
    input  logic                       IMemValid,
    input  logic [BITS-1:0]            IMemRdata,
    output logic [BITS-1:0]            InstrF,
    output logic [BITS-1:0]            PCPlus4F,
    output logic                       ValidF,
    output logic [$clog2(DEPTH+1)-1:0] CountF
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [BITS-1:0]  fetch_pc_q, fetch_pc_d;
    logic [BITS-1:0]  instr_q [DEPTH];
    logic [BITS-1:0]  instr_d [DEPTH];
    logic [BITS-1:0]  pc4_q   [DEPTH];
    logic [BITS-1:0]  pc4_d   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [BITS-1:0]  req_addr_q, req_addr_d;
    logic             drop_q, drop_d;

    logic            redirect;
    logic [BITS-1:0] target;
    logic            room;
    logic            req;
    logic            grant;
    logic            resp;
    logic            push;
    logic            pop;

    always_comb begin
        redirect = BranchE || PCSrcW;
        target   = BranchE ? ALUSResultE : ResultW;
        // An in-flight request already owns a queue slot.
        room     = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W + 1)'(DEPTH);
        req      = !RESET && !redirect && !drop_q && room && (!inflight_q || IMemValid);
        grant    = req && IMemGnt;
        resp     = inflight_q && IMemValid;
        push     = resp && !drop_q && !redirect;
        pop      = (count_q != '0) && !StallF && !redirect;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;

        if (redirect) begin
            fetch_pc_d = target;
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + BITS'(4);
        end

        if (grant) begin
            req_addr_d = fetch_pc_q;
        end

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = IMemRdata;
                pc4_d[wr_ptr_q]   = req_addr_q + BITS'(4);
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // A pending drop is retired only by its own response, even across further redirects.
        if (drop_q) begin
            if (resp) begin
                drop_d     = 1'b0;
                inflight_d = 1'b0;
            end
        end else if (redirect) begin
            if (inflight_q) begin
                if (IMemValid) begin
                    inflight_d = 1'b0;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end else begin
            if (resp) begin
                inflight_d = 1'b0;
            end
            if (grant) begin
                inflight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
            drop_q     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc4_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
        end
    end

    always_comb begin
        IMemReq  = req;
        IMemAddr = fetch_pc_q;
        InstrF   = instr_q[rd_ptr_q];
        PCPlus4F = pc4_q[rd_ptr_q];
        ValidF   = (count_q != '0);
        CountF   = count_q;
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: per-cycle vector table with a fixed-latency
// memory model, plus hand sequences for in-flight redirect and mid-transaction reset.
module tb_fetch_prefetch_queue;

    logic        CLK = 1'b0;
    logic        RESET, BranchE, PCSrcW, StallF;
    logic [31:0] ALUSResultE, ResultW;
    logic        IMemReq, IMemGnt, IMemValid;
    logic [31:0] IMemAddr, IMemRdata;
    logic [31:0] InstrF, PCPlus4F;
    logic        ValidF;
    logic [2:0]  CountF;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic        mem_busy;
    int          mem_cnt;
    int          mem_lat;
    logic [31:0] mem_addr;

    always #5 CLK = ~CLK;

    fetch_prefetch_queue #(
        .BITS     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BranchE     (BranchE),
        .ALUSResultE (ALUSResultE),
        .PCSrcW      (PCSrcW),
        .ResultW     (ResultW),
        .StallF      (StallF),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemGnt     (IMemGnt),
        .IMemValid   (IMemValid),
        .IMemRdata   (IMemRdata),
        .InstrF      (InstrF),
        .PCPlus4F    (PCPlus4F),
        .ValidF      (ValidF),
        .CountF      (CountF)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] alu;
        logic        pcs;
        logic [31:0] resw;
        logic        exp_valid;
        logic [2:0]  exp_cnt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        chk_head;
        logic [31:0] exp_pc4;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl [28];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t row(input logic rst, input logic stall, input logic br,
                                 input logic [31:0] alu, input logic pcs, input logic [31:0] resw,
                                 input logic v, input logic [2:0] c, input logic rq,
                                 input logic [31:0] addr, input logic h, input logic [31:0] pc4);
        vec_t r;
        r.rst       = rst;
        r.stall     = stall;
        r.br        = br;
        r.alu       = alu;
        r.pcs       = pcs;
        r.resw      = resw;
        r.exp_valid = v;
        r.exp_cnt   = c;
        r.exp_req   = rq;
        r.exp_addr  = addr;
        r.chk_head  = h;
        r.exp_pc4   = pc4;
        r.exp_instr = v ? word_of(pc4 - 32'd4) : 32'h0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive this cycle's memory response, then let combinational outputs settle.
    task automatic step();
        IMemValid = 1'b0;
        IMemRdata = 32'hDEAD_BEEF;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                IMemValid = 1'b1;
                IMemRdata = word_of(mem_addr);
                mem_busy  = 1'b0;
            end
        end
        #1;
    endtask

    task automatic tick();
        if (IMemReq && IMemGnt) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = IMemAddr;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int   k;
        int   waited;
        logic found;

        //              rst stl br alu          pcs resw          v  c  rq addr          h  pc4
        tbl[0]  = row(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h100,      1, 32'h0);
        tbl[1]  = row(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h100,      0, 32'h0);
        tbl[2]  = row(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h104,      0, 32'h0);
        tbl[3]  = row(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h108,      1, 32'h104);
        tbl[4]  = row(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h10C,      1, 32'h108);
        tbl[5]  = row(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h110,      1, 32'h10C);
        tbl[6]  = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h114,      1, 32'h110);
        tbl[7]  = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 2, 1, 32'h118,      1, 32'h110);
        tbl[8]  = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 3, 0, 32'h11C,      1, 32'h110);
        tbl[9]  = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 4, 0, 32'h11C,      1, 32'h110);
        tbl[10] = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 4, 0, 32'h11C,      1, 32'h110);
        tbl[11] = row(0, 0, 0, 32'h0,        0, 32'h0,        1, 4, 0, 32'h11C,      1, 32'h110);
        tbl[12] = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 3, 1, 32'h11C,      1, 32'h114);
        tbl[13] = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 3, 0, 32'h120,      1, 32'h114);
        tbl[14] = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 4, 0, 32'h120,      1, 32'h114);
        tbl[15] = row(0, 1, 1, 32'h300,      1, 32'h400,      1, 4, 0, 32'h120,      1, 32'h114);
        tbl[16] = row(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h300,      0, 32'h0);
        tbl[17] = row(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h304,      0, 32'h0);
        tbl[18] = row(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h308,      1, 32'h304);
        tbl[19] = row(0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 1, 0, 32'h30C,      1, 32'h308);
        tbl[20] = row(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hFFFFFFFC, 0, 32'h0);
        tbl[21] = row(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0,        0, 32'h0);
        tbl[22] = row(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h4,        1, 32'h0);
        tbl[23] = row(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'h8,        1, 32'h4);
        tbl[24] = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 1, 32'hC,        1, 32'h8);
        tbl[25] = row(0, 1, 0, 32'h0,        0, 32'h0,        1, 2, 1, 32'h10,       1, 32'h8);
        tbl[26] = row(1, 1, 0, 32'h0,        0, 32'h0,        1, 3, 0, 32'h14,       1, 32'h8);
        tbl[27] = row(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h100,      1, 32'h0);

        RESET       = 1'b1;
        BranchE     = 1'b0;
        PCSrcW      = 1'b0;
        StallF      = 1'b0;
        ALUSResultE = '0;
        ResultW     = '0;
        IMemGnt     = 1'b1;
        IMemValid   = 1'b0;
        IMemRdata   = '0;
        mem_busy    = 1'b0;
        mem_cnt     = 0;
        mem_lat     = 1;
        mem_addr    = '0;

        @(posedge CLK);
        #1;
        repeat (2) begin
            step();
            tick();
        end

        for (int i = 0; i < 28; i++) begin
            RESET       = tbl[i].rst;
            StallF      = tbl[i].stall;
            BranchE     = tbl[i].br;
            ALUSResultE = tbl[i].alu;
            PCSrcW      = tbl[i].pcs;
            ResultW     = tbl[i].resw;
            step();
            chk($sformatf("r%0d ValidF", i), 32'(ValidF), 32'(tbl[i].exp_valid));
            chk($sformatf("r%0d CountF", i), 32'(CountF), 32'(tbl[i].exp_cnt));
            chk($sformatf("r%0d IMemReq", i), 32'(IMemReq), 32'(tbl[i].exp_req));
            chk($sformatf("r%0d IMemAddr", i), IMemAddr, tbl[i].exp_addr);
            if (tbl[i].chk_head) begin
                chk($sformatf("r%0d PCPlus4F", i), PCPlus4F, tbl[i].exp_pc4);
                chk($sformatf("r%0d InstrF", i), InstrF, tbl[i].exp_instr);
            end
            tick();
        end

        // Redirect while a 3-cycle request is outstanding.
        RESET       = 1'b1;
        BranchE     = 1'b0;
        PCSrcW      = 1'b0;
        StallF      = 1'b0;
        k = 0;
        while (mem_busy && k < 10) begin
            step();
            tick();
            k++;
        end
        step();
        tick();
        mem_lat = 3;
        RESET   = 1'b0;

        step();
        chk("A req first", 32'(IMemReq), 32'd1);
        chk("A addr first", IMemAddr, 32'h100);
        tick();
        step();
        chk("A req while busy", 32'(IMemReq), 32'd0);
        tick();
        BranchE     = 1'b1;
        ALUSResultE = 32'h200;
        step();
        chk("A req redirect", 32'(IMemReq), 32'd0);
        tick();
        BranchE = 1'b0;
        step();
        chk("A flush ValidF", 32'(ValidF), 32'd0);
        chk("A flush CountF", 32'(CountF), 32'd0);
        chk("A req drop", 32'(IMemReq), 32'd0);
        tick();
        step();
        chk("A stale CountF", 32'(CountF), 32'd0);
        chk("A req target", 32'(IMemReq), 32'd1);
        chk("A addr target", IMemAddr, 32'h200);
        tick();
        waited = 0;
        found  = 1'b0;
        while (!found && waited < 10) begin
            step();
            if (ValidF) begin
                found = 1'b1;
            end else begin
                tick();
                waited++;
            end
        end
        chk("A ValidF seen", 32'(found), 32'd1);
        chk("A ValidF latency", 32'(waited), 32'd3);
        chk("A PCPlus4F", PCPlus4F, 32'h204);
        chk("A InstrF", InstrF, word_of(32'h200));
        tick();

        // Fill to three entries plus one in flight, then reset mid-transaction.
        StallF = 1'b1;
        found  = 1'b0;
        k      = 0;
        while (!found && k < 60) begin
            step();
            tick();
            k++;
            if (CountF == 3'd3 && mem_busy) found = 1'b1;
        end
        chk("B fill reached", 32'(found), 32'd1);
        RESET = 1'b1;
        step();
        chk("B req in reset", 32'(IMemReq), 32'd0);
        tick();
        RESET   = 1'b0;
        StallF  = 1'b0;
        IMemGnt = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("B%0d ValidF", j), 32'(ValidF), 32'd0);
            chk($sformatf("B%0d CountF", j), 32'(CountF), 32'd0);
            chk($sformatf("B%0d IMemReq", j), 32'(IMemReq), 32'd1);
            chk($sformatf("B%0d IMemAddr", j), IMemAddr, 32'h100);
            chk($sformatf("B%0d PCPlus4F", j), PCPlus4F, 32'h0);
            tick();
        end
        IMemGnt = 1'b1;
        step();
        chk("B req restart", 32'(IMemReq), 32'd1);
        chk("B addr restart", IMemAddr, 32'h100);
        tick();
        waited = 0;
        found  = 1'b0;
        while (!found && waited < 10) begin
            step();
            if (ValidF) begin
                found = 1'b1;
            end else begin
                tick();
                waited++;
            end
        end
        chk("B ValidF seen", 32'(found), 32'd1);
        chk("B ValidF latency", 32'(waited), 32'd3);
        chk("B CountF", 32'(CountF), 32'd1);
        chk("B PCPlus4F", PCPlus4F, 32'h104);
        chk("B InstrF", InstrF, word_of(32'h100));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
